// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: absorbs the one-cycle read latency and
// packs Ratio narrow words per wide beat onto a valid/ready stream, with flush.
module fifo_rd_packer #(
    parameter int Width = 4,
    parameter int Ratio = 4,
    parameter int CntW  = 16
) (
    input  logic                     rclk,
    input  logic                     r_rst,
    input  logic                     fifo_empty,
    input  logic [Width-1:0]         fifo_rdata,
    output logic                     fifo_ren,
    input  logic                     flush,
    output logic [Width*Ratio-1:0]   out_data,
    output logic [Ratio-1:0]         out_keep,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CntW-1:0]          beat_cnt
);

    localparam int CW = $clog2(Ratio + 1);
    localparam int LW = (Ratio > 1) ? $clog2(Ratio) : 1;

    logic [CW-1:0]                 r_cnt;
    logic                          r_rd_pend;
    logic                          r_flush_pend;
    logic [Ratio-1:0][Width-1:0]   r_acc;
    logic [Ratio-1:0][Width-1:0]   r_out_data;
    logic [Ratio-1:0]              r_out_keep;
    logic                          r_out_valid;
    logic [CntW-1:0]               r_beat_cnt;

    logic [CW:0]                   w_fill;
    logic                          w_has_data;
    logic                          w_flush_req;
    logic                          w_slot_free;
    logic                          w_full;
    logic                          w_handoff;
    logic [LW-1:0]                 w_lane;
    logic [CW-1:0]                 w_cnt_base;
    logic [CW-1:0]                 w_cnt_nxt;
    logic [Ratio-1:0]              w_keep;
    logic [Ratio-1:0][Width-1:0]   w_beat;

    assign w_fill      = {1'b0, r_cnt} + (CW + 1)'(r_rd_pend);
    assign w_has_data  = (r_cnt != '0) | r_rd_pend;
    // A flush arriving with a word still in flight must stop further reads at once,
    // otherwise a fresh word would slip into the partial beat before it closes.
    assign w_flush_req = r_flush_pend | (flush & w_has_data);
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_full      = (r_cnt == CW'(Ratio));
    assign w_handoff   = w_slot_free &
                         (w_full | (w_flush_req & ~r_rd_pend & (r_cnt != '0)));

    assign fifo_ren    = r_rst & ~fifo_empty & ~w_flush_req & (w_fill < (CW + 1)'(Ratio));

    assign w_lane      = w_handoff ? '0 : r_cnt[LW-1:0];
    assign w_cnt_base  = w_handoff ? '0 : r_cnt;
    assign w_cnt_nxt   = w_cnt_base + CW'(r_rd_pend);

    always_comb begin
        w_keep = '0;
        w_beat = '0;
        for (int unsigned i = 0; i < Ratio; i++) begin
            w_keep[i] = (i < 32'(r_cnt));
            w_beat[i] = w_keep[i] ? r_acc[i] : '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (r_rst && r_rd_pend) begin
            r_acc[w_lane] <= fifo_rdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (!r_rst) begin
            r_cnt        <= '0;
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_valid  <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            r_rd_pend    <= fifo_ren;
            r_flush_pend <= w_flush_req & ~w_handoff;
            r_cnt        <= w_cnt_nxt;
            if (w_handoff) begin
                r_out_data  <= w_beat;
                r_out_keep  <= w_keep;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready) begin
                r_beat_cnt <= r_beat_cnt + CntW'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule
